// File: rtl/fft_output_reorder_if.sv
// Sample stream bundle between the last SDF stage and the reorder buffer.
// FFT_REORDER_SOF_EN adds the do_sof frame marker to the output side.
interface fft_output_reorder_if #(
    parameter int WIDTH = 16
);
    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;
`ifdef FFT_REORDER_SOF_EN
    logic                    do_sof;
`endif

    // master is the pipeline side: produces di_*, consumes do_*
    modport master (
        output di_en, di_re, di_im,
`ifdef FFT_REORDER_SOF_EN
        input  do_sof,
`endif
        input  do_en, do_re, do_im
    );

    modport slave (
        input  di_en, di_re, di_im,
`ifdef FFT_REORDER_SOF_EN
        output do_sof,
`endif
        output do_en, do_re, do_im
    );
endinterface

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: captures a bit-reversed FFT frame, replays it in natural order.
// Optional start-of-frame output do_sof is enabled by defining FFT_REORDER_SOF_EN.
module fft_output_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic               clock,
    input  logic               reset,
    fft_output_reorder_if.slave io
);

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t             state;
    logic [LOG_N-1:0]   wr_cnt;
    logic [LOG_N-1:0]   rd_cnt;
    logic               wr_bank;
    logic               rd_bank;
    logic               rd_valid;
    logic [2*WIDTH-1:0] rd_data;
    logic [2*WIDTH-1:0] mem [2*N];
    logic               launch;
`ifdef FFT_REORDER_SOF_EN
    logic               rd_first;
`endif

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    // Last sample of a frame accepted: hand the filled bank to the read side
    assign launch = reset && io.di_en && (wr_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (io.di_en) begin
            wr_cnt <= wr_cnt + LOG_N'(1);
            if (wr_cnt == CNT_LAST) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // NOTE: the banks have no reset so they map onto plain RAM; stale contents
    // are never visible because every read follows a complete frame write.
    always_ff @(posedge clock) begin
        if (reset && io.di_en) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= {io.di_re, io.di_im};
        end
        rd_data <= mem[{rd_bank, rd_cnt}];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
            rd_valid <= 1'b0;
`ifdef FFT_REORDER_SOF_EN
            rd_first <= 1'b0;
`endif
        end else begin
            rd_valid <= (state == READ);
`ifdef FFT_REORDER_SOF_EN
            rd_first <= (state == READ) && (rd_cnt == '0);
`endif
            if (launch) begin
                state   <= READ;
                rd_cnt  <= '0;
                rd_bank <= wr_bank;
            end else if (state == READ) begin
                rd_cnt <= rd_cnt + LOG_N'(1);
                if (rd_cnt == CNT_LAST) begin
                    state <= IDLE;
                end
            end
        end
    end

    // Output data holds its last value between bursts
    always_ff @(posedge clock) begin
        if (!reset) begin
            io.do_en <= 1'b0;
            io.do_re <= '0;
            io.do_im <= '0;
`ifdef FFT_REORDER_SOF_EN
            io.do_sof <= 1'b0;
`endif
        end else begin
            io.do_en <= rd_valid;
            if (rd_valid) begin
                io.do_re <= rd_data[2*WIDTH-1:WIDTH];
                io.do_im <= rd_data[WIDTH-1:0];
            end
`ifdef FFT_REORDER_SOF_EN
            io.do_sof <= rd_first;
`endif
        end
    end

    // A new frame may only complete when the previous burst is idle or on its last read
    launch_while_reading: assert property (
        @(posedge clock) disable iff (!reset)
        launch |-> (state == IDLE || rd_cnt == CNT_LAST)
    );

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: frame table plus reset corner sequences,
// with a cycle-accurate scoreboard on the output stream.
module tb_fft_output_reorder;

    localparam int WIDTH = 16;
    localparam int LOG_N = 6;
    localparam int N     = 1 << LOG_N;
    localparam int SENT  = -99999;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fft_output_reorder_if #(.WIDTH(WIDTH)) io ();

    fft_output_reorder #(.WIDTH(WIDTH), .LOG_N(LOG_N)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    typedef struct {
        int frame;
        int n;
        int re;
        int im;
        bit sof;
        int cyc;
    } exp_t;

    typedef struct {
        string name;
        int    base;
        int    gap;
        bit    drain;
    } frame_vec_t;

    typedef struct {
        int frame;
        int n;
        int re;
    } spot_t;

    exp_t       sb[$];
    frame_vec_t fv[4];
    spot_t      sp[8];
    int         cap_re[8][N];
    int         cap_im[8][N];
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         sof_count = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOG_N; i++) begin
            if (((v >> i) & 1) != 0) r |= 1 << (LOG_N - 1 - i);
        end
        return r;
    endfunction

    // Output monitor: every valid sample must match the scoreboard head, on the predicted cycle
    always @(negedge clock) begin
        exp_t e;
        if (io.do_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected do_en", int'(io.do_en), 0);
            end else begin
                e = sb.pop_front();
                cap_re[e.frame][e.n] = int'($signed(io.do_re));
                cap_im[e.frame][e.n] = int'($signed(io.do_im));
                check($sformatf("do_re f%0d n%0d", e.frame, e.n), int'($signed(io.do_re)), e.re);
                check($sformatf("do_im f%0d n%0d", e.frame, e.n), int'($signed(io.do_im)), e.im);
                check($sformatf("out cycle f%0d n%0d", e.frame, e.n), cyc, e.cyc);
`ifdef FFT_REORDER_SOF_EN
                check($sformatf("do_sof f%0d n%0d", e.frame, e.n), int'(io.do_sof), int'(e.sof));
`endif
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check($sformatf("missing do_en f%0d n%0d", e.frame, e.n), int'(io.do_en), 1);
        end
`ifdef FFT_REORDER_SOF_EN
        if (io.do_sof === 1'b1) sof_count++;
        if (io.do_en !== 1'b1) check("do_sof while idle", int'(io.do_sof), 0);
`endif
    end

    task automatic send_frame(input int frame, input int base, input int gap,
                              input int count, input bit push);
        for (int i = 0; i < count; i++) begin
            io.di_en = 1'b1;
            io.di_re = WIDTH'(base + i);
            io.di_im = WIDTH'(-(base + i));
            @(posedge clock);
            #1;
            io.di_en = 1'b0;
            if (gap > 0 && i < count - 1) begin
                repeat (gap) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        if (push) begin
            for (int n = 0; n < N; n++) begin
                sb.push_back('{frame, n, base + bitrev(n), -(base + bitrev(n)), n == 0,
                               cyc + 2 + n});
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb.size() > 0; t++) @(posedge clock);
        check("scoreboard drained", sb.size(), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        int sof_before;

        fv[0] = '{"single",  0,   0, 1'b1};
        fv[1] = '{"b2b f1",  0,   0, 1'b0};
        fv[2] = '{"b2b f2",  100, 0, 1'b1};
        fv[3] = '{"gapped",  200, 1, 1'b1};

        sp[0] = '{0, 0,  0};
        sp[1] = '{0, 1,  32};
        sp[2] = '{0, 2,  16};
        sp[3] = '{0, 63, 63};
        sp[4] = '{1, 2,  16};
        sp[5] = '{2, 1,  132};
        sp[6] = '{3, 1,  232};
        sp[7] = '{3, 63, 263};

        for (int f = 0; f < 8; f++) begin
            for (int n = 0; n < N; n++) begin
                cap_re[f][n] = SENT;
                cap_im[f][n] = SENT;
            end
        end

        io.di_en = 1'b0;
        io.di_re = '0;
        io.di_im = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset do_en", int'(io.do_en), 0);
        check("reset do_re", int'($signed(io.do_re)), 0);
        check("reset do_im", int'($signed(io.do_im)), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        sof_before = 0;
        for (int f = 0; f < 4; f++) begin
            if (f == 1) sof_before = sof_count;
            send_frame(f, fv[f].base, fv[f].gap, N, 1'b1);
            if (fv[f].drain) drain();
`ifdef FFT_REORDER_SOF_EN
            if (f == 2) check("sof pulses in b2b", sof_count - sof_before, 2);
`endif
        end

        for (int s = 0; s < 8; s++) begin
            check($sformatf("spot re f%0d n%0d", sp[s].frame, sp[s].n),
                  cap_re[sp[s].frame][sp[s].n], sp[s].re);
            check($sformatf("spot im f%0d n%0d", sp[s].frame, sp[s].n),
                  cap_im[sp[s].frame][sp[s].n], -sp[s].re);
        end

        // Reset after 20 samples of a frame; di_en held high through the reset cycle
        send_frame(7, 500, 0, 20, 1'b0);
        io.di_en = 1'b1;
        io.di_re = WIDTH'(777);
        io.di_im = WIDTH'(-777);
        reset    = 1'b0;
        @(posedge clock);
        #1;
        check("mid-frame reset do_en", int'(io.do_en), 0);
        check("mid-frame reset do_re", int'($signed(io.do_re)), 0);
        check("mid-frame reset do_im", int'($signed(io.do_im)), 0);
        reset    = 1'b1;
        io.di_en = 1'b0;
        @(posedge clock);
        #1;
        send_frame(4, 300, 0, N, 1'b1);
        drain();
        check("post-reset frame n0", cap_re[4][0], 300);
        check("post-reset frame n1", cap_re[4][1], 332);
        check("post-reset frame n63", cap_re[4][63], 363);

        // Reset while output index 10 is on the bus
        send_frame(5, 400, 0, N, 1'b1);
        repeat (12) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid-burst reset do_en", int'(io.do_en), 0);
        sb.delete();
        reset = 1'b1;
        repeat (100) begin
            @(posedge clock);
            #1;
        end
        check("burst index 10 seen", cap_re[5][10], 420);
        check("burst index 11 aborted", cap_re[5][11], SENT);

        send_frame(6, 600, 0, N, 1'b1);
        drain();
        check("recovery frame n5", cap_re[6][5], 640);
        check("recovery frame n0", cap_re[6][0], 600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
